// File: rtl/risc_v_ex_mem_wb.sv
// Back half of a 5-stage RV32I pipeline: ID/EX, EX/MEM, MEM/WB registers, ALU, branch unit,
// data memory and WB mux. Define FORWARDING_EN to forward EX operands from EX/MEM and MEM/WB.
module risc_v_ex_mem_wb #(
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ID_EX_flush,
    input  logic [31:0] PC_ID,
    input  logic [31:0] IMM_ID,
    input  logic [31:0] REG_DATA1_ID,
    input  logic [31:0] REG_DATA2_ID,
    input  logic [2:0]  FUNCT3_ID,
    input  logic [6:0]  FUNCT7_ID,
    input  logic [6:0]  OPCODE_ID,
    input  logic [4:0]  RD_ID,
    input  logic [4:0]  RS1_ID,
    input  logic [4:0]  RS2_ID,
    output logic        PCSrc,
    output logic [31:0] PC_Branch,
    output logic        MemRead_EX,
    output logic [4:0]  RD_EX,
    output logic        RegWrite_WB,
    output logic [31:0] ALU_DATA_WB,
    output logic [4:0]  RD_WB
);
    localparam int unsigned AW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef struct packed {
        logic        reg_write, mem_read, mem_write, branch, use_imm, is_r;
        logic [31:0] pc, imm, rs1_data, rs2_data;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [4:0]  rd, rs1, rs2;
    } id_ex_t;

    typedef struct packed {
        logic        reg_write, mem_read, mem_write;
        logic [31:0] alu, store_data;
        logic [4:0]  rd;
    } ex_mem_t;

    typedef struct packed {
        logic        reg_write, mem_read;
        logic [31:0] alu, mem_data;
        logic [4:0]  rd;
    } mem_wb_t;

    id_ex_t  id_ex_d, id_ex_q;
    ex_mem_t ex_mem_d, ex_mem_q;
    mem_wb_t mem_wb_d, mem_wb_q;

    logic [31:0] dmem_q [DMEM_WORDS];
    logic [AW-1:0] mem_idx;

    logic [31:0] op_a, rs2_val, op_b, alu_res;
    logic [4:0]  shamt;
    logic        taken;

    // ID/EX capture: a taken branch in EX squashes the wrong-path instruction in ID.
    always_comb begin
        id_ex_d = '0;
        if (!(ID_EX_flush || PCSrc)) begin
            id_ex_d.pc       = PC_ID;
            id_ex_d.imm      = IMM_ID;
            id_ex_d.rs1_data = REG_DATA1_ID;
            id_ex_d.rs2_data = REG_DATA2_ID;
            id_ex_d.funct3   = FUNCT3_ID;
            id_ex_d.funct7b5 = FUNCT7_ID[5];
            id_ex_d.rd       = RD_ID;
            id_ex_d.rs1      = RS1_ID;
            id_ex_d.rs2      = RS2_ID;
            case (OPCODE_ID)
                OP_R:  begin id_ex_d.reg_write = 1'b1; id_ex_d.is_r = 1'b1; end
                OP_I:  begin id_ex_d.reg_write = 1'b1; id_ex_d.use_imm = 1'b1; end
                OP_LW: begin
                    id_ex_d.reg_write = 1'b1;
                    id_ex_d.mem_read  = 1'b1;
                    id_ex_d.use_imm   = 1'b1;
                end
                OP_SW: begin id_ex_d.mem_write = 1'b1; id_ex_d.use_imm = 1'b1; end
                OP_BR: id_ex_d.branch = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef FORWARDING_EN
    logic fwd_mem;
    assign fwd_mem = ex_mem_q.reg_write && !ex_mem_q.mem_read && (ex_mem_q.rd != 5'd0);
`endif

    always_comb begin
        op_a    = id_ex_q.rs1_data;
        rs2_val = id_ex_q.rs2_data;
`ifdef FORWARDING_EN
        // RegWrite_WB already excludes x0, and fwd_mem does too.
        if (fwd_mem && ex_mem_q.rd == id_ex_q.rs1)     op_a = ex_mem_q.alu;
        else if (RegWrite_WB && RD_WB == id_ex_q.rs1)  op_a = ALU_DATA_WB;
        if (fwd_mem && ex_mem_q.rd == id_ex_q.rs2)     rs2_val = ex_mem_q.alu;
        else if (RegWrite_WB && RD_WB == id_ex_q.rs2)  rs2_val = ALU_DATA_WB;
`endif
        op_b = id_ex_q.use_imm ? id_ex_q.imm : rs2_val;
    end

    assign shamt = op_b[4:0];

    always_comb begin
        alu_res = '0;
        unique case (id_ex_q.funct3)
            3'b000: alu_res = (id_ex_q.is_r && id_ex_q.funct7b5) ? op_a - op_b : op_a + op_b;
            3'b001: alu_res = op_a << shamt;
            3'b010: alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
            3'b011: alu_res = {31'b0, op_a < op_b};
            3'b100: alu_res = op_a ^ op_b;
            3'b101: alu_res = id_ex_q.funct7b5 ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
            3'b110: alu_res = op_a | op_b;
            3'b111: alu_res = op_a & op_b;
        endcase
        if (id_ex_q.mem_read || id_ex_q.mem_write) begin
            alu_res = op_a + op_b;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (id_ex_q.funct3)
            3'b000: taken = (op_a == rs2_val);
            3'b001: taken = (op_a != rs2_val);
            3'b100: taken = ($signed(op_a) < $signed(rs2_val));
            3'b101: taken = ($signed(op_a) >= $signed(rs2_val));
            3'b110: taken = (op_a < rs2_val);
            3'b111: taken = (op_a >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    assign PCSrc      = id_ex_q.branch && taken;
    assign PC_Branch  = id_ex_q.pc + id_ex_q.imm;
    assign MemRead_EX = id_ex_q.mem_read;
    assign RD_EX      = id_ex_q.rd;

    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.alu        = alu_res;
        ex_mem_d.store_data = rs2_val;
        ex_mem_d.rd         = id_ex_q.rd;
    end

    assign mem_idx = ex_mem_q.alu[AW+1:2];

    // Memory contents survive reset; a store caught by reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && ex_mem_q.mem_write) begin
            dmem_q[mem_idx] <= ex_mem_q.store_data;
        end
    end

    always_comb begin
        mem_wb_d           = '0;
        mem_wb_d.reg_write = ex_mem_q.reg_write;
        mem_wb_d.mem_read  = ex_mem_q.mem_read;
        mem_wb_d.alu       = ex_mem_q.alu;
        mem_wb_d.mem_data  = dmem_q[mem_idx];
        mem_wb_d.rd        = ex_mem_q.rd;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign RegWrite_WB = mem_wb_q.reg_write && (mem_wb_q.rd != 5'd0);
    assign ALU_DATA_WB = mem_wb_q.mem_read ? mem_wb_q.mem_data : mem_wb_q.alu;
    assign RD_WB       = mem_wb_q.rd;

    logic unused_bits;
`ifdef FORWARDING_EN
    assign unused_bits = ^{FUNCT7_ID[6], FUNCT7_ID[4:0], ex_mem_q.alu[31:AW+2],
                           ex_mem_q.alu[1:0]};
`else
    assign unused_bits = ^{FUNCT7_ID[6], FUNCT7_ID[4:0], ex_mem_q.alu[31:AW+2],
                           ex_mem_q.alu[1:0], id_ex_q.rs1, id_ex_q.rs2};
`endif

endmodule

// File: tb/tb_risc_v_ex_mem_wb.sv
// Self-checking bench for risc_v_ex_mem_wb: directed scenarios plus a randomized instruction
// stream checked against an architectural model (honours FORWARDING_EN when defined).
`timescale 1ns/1ps
module tb_risc_v_ex_mem_wb;
    localparam int unsigned DMEM_WORDS = 1024;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
`ifdef FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ID_EX_flush;
    logic [31:0] PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID;
    logic [2:0]  FUNCT3_ID;
    logic [6:0]  FUNCT7_ID, OPCODE_ID;
    logic [4:0]  RD_ID, RS1_ID, RS2_ID;
    logic        PCSrc, MemRead_EX, RegWrite_WB;
    logic [31:0] PC_Branch, ALU_DATA_WB;
    logic [4:0]  RD_EX, RD_WB;

    int checks = 0;
    int failures = 0;

    risc_v_ex_mem_wb #(.DMEM_WORDS(DMEM_WORDS)) dut (
        .clk(clk), .reset(reset), .ID_EX_flush(ID_EX_flush), .PC_ID(PC_ID), .IMM_ID(IMM_ID),
        .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID), .FUNCT3_ID(FUNCT3_ID),
        .FUNCT7_ID(FUNCT7_ID), .OPCODE_ID(OPCODE_ID), .RD_ID(RD_ID), .RS1_ID(RS1_ID),
        .RS2_ID(RS2_ID), .PCSrc(PCSrc), .PC_Branch(PC_Branch), .MemRead_EX(MemRead_EX),
        .RD_EX(RD_EX), .RegWrite_WB(RegWrite_WB), .ALU_DATA_WB(ALU_DATA_WB), .RD_WB(RD_WB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] pc, imm, a, b;
        logic        flush;
    } instr_t;

    typedef struct {
        bit          live, we, lw, br, taken;
        logic [31:0] data, tgt;
        logic [4:0]  rd;
    } exp_t;

    logic [31:0] mem_m [int];
    int          stored_q[$];

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [31:0] a, input logic [31:0] b);
        instr_t i;
        i.op = op; i.f3 = f3; i.f7 = f7; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.pc = pc; i.imm = imm; i.a = a; i.b = b; i.flush = 1'b0;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endfunction

    // Architectural ALU: written from the instruction semantics, not the datapath.
    function automatic logic [31:0] ref_alu(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        logic [31:0] na;
        sh = int'(b % 32);
        na = ~a;
        case (f3)
            3'd0: return (op == OP_R && f7[5]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return !f7[5] ? a >> sh : (a[31] ? ~(na >> sh) : a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic bit ref_taken(input logic [2:0] f3, input logic [31:0] a,
                                     input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) < int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input instr_t i);
        ID_EX_flush = i.flush; PC_ID = i.pc; IMM_ID = i.imm;
        REG_DATA1_ID = i.a; REG_DATA2_ID = i.b; FUNCT3_ID = i.f3; FUNCT7_ID = i.f7;
        OPCODE_ID = i.op; RD_ID = i.rd; RS1_ID = i.rs1; RS2_ID = i.rs2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bubbles(input int n);
        drive(nop());
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(mk(OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'h40, 32'd0, 32'd5, 32'd7));
        tick();
        tick();
        reset = 1'b0;
        drive(nop());
        checks++; if (RegWrite_WB !== 1'b0) begin failures++;
            $display("FAIL reset_regwrite got=%0b exp=0", RegWrite_WB); end
        checks++; if (ALU_DATA_WB !== 32'd0) begin failures++;
            $display("FAIL reset_wbdata got=%h exp=0", ALU_DATA_WB); end
        checks++; if (PCSrc !== 1'b0) begin failures++;
            $display("FAIL reset_pcsrc got=%0b exp=0", PCSrc); end
        checks++; if (RD_WB !== 5'd0 || MemRead_EX !== 1'b0 || PC_Branch !== 32'd0) begin
            failures++;
            $display("FAIL reset_misc got rd_wb=%0d memrd=%0b pcb=%h exp=0", RD_WB, MemRead_EX,
                     PC_Branch); end
        bubbles(3);
    endtask

    task automatic test_r_type();
        drive(mk(OP_R, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 32'd0, 32'd5, 32'd7));
        tick();
        drive(nop());
        tick();
        tick();
        checks++; if (RegWrite_WB !== 1'b1 || RD_WB !== 5'd3 || ALU_DATA_WB !== 32'd12) begin
            failures++;
            $display("FAIL r_add got we=%0b rd=%0d data=%0d exp we=1 rd=3 data=12",
                     RegWrite_WB, RD_WB, ALU_DATA_WB); end
        bubbles(3);
    endtask

    task automatic test_i_type();
        drive(mk(OP_I, 3'd5, 7'h20, 5'd4, 5'd1, 5'd0, 32'd0, 32'h404, 32'h8000_0000, 32'd9));
        tick();
        drive(mk(OP_I, 3'd0, 7'h20, 5'd7, 5'd2, 5'd0, 32'd0, 32'd5, 32'd10, 32'd3));
        tick();
        drive(nop());
        tick();
        checks++; if (ALU_DATA_WB !== 32'hF800_0000 || RegWrite_WB !== 1'b1) begin failures++;
            $display("FAIL i_srai got=%h we=%0b exp=f8000000 we=1", ALU_DATA_WB, RegWrite_WB);
        end
        tick();
        checks++; if (ALU_DATA_WB !== 32'd15 || RD_WB !== 5'd7) begin failures++;
            $display("FAIL i_addi_f7 got=%0d rd=%0d exp=15 rd=7", ALU_DATA_WB, RD_WB); end
        bubbles(3);
    endtask

    task automatic test_branch();
        drive(mk(OP_BR, 3'd0, 7'd0, 5'd0, 5'd7, 5'd8, 32'h40, 32'h10, 32'h1234, 32'h1234));
        tick();
        checks++; if (PCSrc !== 1'b1 || PC_Branch !== 32'h50) begin failures++;
            $display("FAIL beq_taken got pcsrc=%0b tgt=%h exp pcsrc=1 tgt=50", PCSrc, PC_Branch);
        end
        drive(mk(OP_R, 3'd0, 7'd0, 5'd5, 5'd9, 5'd10, 32'h44, 32'd0, 32'd1, 32'd1));
        tick();
        drive(nop());
        checks++; if (PCSrc !== 1'b0) begin failures++;
            $display("FAIL beq_pulse got pcsrc=%0b exp=0", PCSrc); end
        tick();
        checks++; if (RegWrite_WB !== 1'b0) begin failures++;
            $display("FAIL beq_no_wb got=%0b exp=0", RegWrite_WB); end
        tick();
        checks++; if (RegWrite_WB !== 1'b0) begin failures++;
            $display("FAIL squash_no_wb got=%0b exp=0", RegWrite_WB); end
        bubbles(3);
    endtask

    task automatic test_sw_lw();
        logic [31:0] alias_base;
        alias_base = 32'(4 * DMEM_WORDS) + 32'd3;
        drive(mk(OP_SW, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd0, 32'd0, 32'h8, 32'hDEAD_BEEF));
        tick();
        drive(mk(OP_LW, 3'd2, 7'd0, 5'd5, 5'd1, 5'd0, 32'd0, 32'd0, 32'h8, 32'd0));
        tick();
        checks++; if (MemRead_EX !== 1'b1 || RD_EX !== 5'd5) begin failures++;
            $display("FAIL lw_in_ex got memrd=%0b rd=%0d exp memrd=1 rd=5", MemRead_EX, RD_EX);
        end
        drive(mk(OP_LW, 3'd2, 7'd0, 5'd6, 5'd1, 5'd0, 32'd0, 32'd8, alias_base, 32'd0));
        tick();
        drive(nop());
        tick();
        checks++; if (ALU_DATA_WB !== 32'hDEAD_BEEF || RD_WB !== 5'd5) begin failures++;
            $display("FAIL sw_lw got=%h rd=%0d exp=deadbeef rd=5", ALU_DATA_WB, RD_WB); end
        tick();
        checks++; if (ALU_DATA_WB !== 32'hDEAD_BEEF || RegWrite_WB !== 1'b1) begin failures++;
            $display("FAIL lw_alias got=%h we=%0b exp=deadbeef we=1", ALU_DATA_WB, RegWrite_WB);
        end
        bubbles(3);
    endtask

    task automatic test_reset_store();
        drive(mk(OP_SW, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd0, 32'd0, 32'h20, 32'h1111_1111));
        tick();
        bubbles(3);
        drive(mk(OP_SW, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd0, 32'd0, 32'h20, 32'h2222_2222));
        tick();
        drive(nop());
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(mk(OP_LW, 3'd2, 7'd0, 5'd6, 5'd1, 5'd0, 32'd0, 32'd0, 32'h20, 32'd0));
        tick();
        drive(nop());
        tick();
        tick();
        checks++; if (ALU_DATA_WB !== 32'h1111_1111) begin failures++;
            $display("FAIL reset_drops_store got=%h exp=11111111", ALU_DATA_WB); end
        bubbles(3);
    endtask

    task automatic test_forwarding();
        logic [31:0] exp2;
        exp2 = FWD ? 32'd6 : 32'd0;
        // EX/MEM path: back-to-back dependency.
        drive(mk(OP_R, 3'd0, 7'd0, 5'd1, 5'd10, 5'd11, 32'd0, 32'd0, 32'd1, 32'd2));
        tick();
        drive(mk(OP_R, 3'd0, 7'd0, 5'd2, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0));
        tick();
        drive(nop());
        tick();
        checks++; if (ALU_DATA_WB !== 32'd3 || RegWrite_WB !== 1'b1) begin failures++;
            $display("FAIL fwd_first got=%0d we=%0b exp=3 we=1", ALU_DATA_WB, RegWrite_WB); end
        tick();
        checks++; if (ALU_DATA_WB !== exp2 || RD_WB !== 5'd2) begin failures++;
            $display("FAIL fwd_exmem got=%0d rd=%0d exp=%0d rd=2", ALU_DATA_WB, RD_WB, exp2); end
        // MEM/WB path: one bubble between producer and consumer.
        drive(mk(OP_R, 3'd0, 7'd0, 5'd1, 5'd10, 5'd11, 32'd0, 32'd0, 32'd1, 32'd2));
        tick();
        drive(nop());
        tick();
        drive(mk(OP_R, 3'd0, 7'd0, 5'd2, 5'd1, 5'd1, 32'd0, 32'd0, 32'd0, 32'd0));
        tick();
        drive(nop());
        tick();
        tick();
        checks++; if (ALU_DATA_WB !== exp2) begin failures++;
            $display("FAIL fwd_memwb got=%0d exp=%0d", ALU_DATA_WB, exp2); end
        // Writer to x0 is neither committed nor forwarded.
        drive(mk(OP_R, 3'd0, 7'd0, 5'd0, 5'd10, 5'd11, 32'd0, 32'd0, 32'd1, 32'd2));
        tick();
        drive(mk(OP_R, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0));
        tick();
        drive(nop());
        tick();
        checks++; if (RegWrite_WB !== 1'b0) begin failures++;
            $display("FAIL x0_no_write got=%0b exp=0", RegWrite_WB); end
        tick();
        checks++; if (ALU_DATA_WB !== 32'd0 || RegWrite_WB !== 1'b1) begin failures++;
            $display("FAIL x0_no_fwd got=%0d we=%0b exp=0 we=1", ALU_DATA_WB, RegWrite_WB); end
        bubbles(3);
    endtask

    task automatic test_random(input int n);
        exp_t expq[$];
        logic [4:0] rec0, rec1;
        bit squash;
        rec0 = '0; rec1 = '0; squash = 1'b0;
        for (int j = 0; j < n + 2; j++) begin
            instr_t ins;
            exp_t e, w;
            int kind, s, idx;
            logic [31:0] addr, tmp;
            bit live;
            ins = nop();
            e = '{default: '0};
            idx = 0;
            if (j < n) begin
                kind = $urandom_range(0, 9);
                ins.rd = 5'($urandom_range(0, 31));
                do ins.rs1 = 5'($urandom_range(0, 31)); while (ins.rs1 == rec0 || ins.rs1 == rec1);
                do ins.rs2 = 5'($urandom_range(0, 31)); while (ins.rs2 == rec0 || ins.rs2 == rec1);
                tmp = $urandom();
                ins.pc = tmp & 32'hFFFF_FFFC;
                ins.a = $urandom();
                ins.b = ($urandom_range(0, 3) == 0) ? ins.a : $urandom();
                ins.f3 = 3'($urandom_range(0, 7));
                s = $urandom_range(0, 255);
                ins.imm = 32'(s - 128);
                if (kind == 6 && stored_q.size() == 0) kind = 7;
                if (kind <= 3) begin
                    ins.op = OP_R;
                    ins.f7 = ((ins.f3 == 3'd0 || ins.f3 == 3'd5) && $urandom_range(0, 1) == 1)
                             ? 7'h20 : 7'h00;
                end else if (kind <= 5) begin
                    ins.op = OP_I;
                    s = $urandom_range(0, 4095);
                    ins.imm = (s >= 2048) ? 32'(s - 4096) : 32'(s);
                    ins.f7 = (ins.f3 == 3'd5) ? (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00)
                                              : 7'($urandom_range(0, 127));
                end else if (kind == 6) begin
                    ins.op = OP_LW;
                    idx = stored_q[$urandom_range(0, stored_q.size() - 1)];
                    tmp = $urandom();
                    addr = (tmp & ~(32'(DMEM_WORDS - 1) << 2)) | (32'(idx) << 2);
                    ins.a = addr - ins.imm;
                end else if (kind == 7) begin
                    ins.op = OP_SW;
                end else if (kind == 8) begin
                    ins.op = OP_BR;
                    s = $urandom_range(0, 511);
                    ins.imm = 32'(s * 2 - 512);
                end else begin
                    s = $urandom_range(0, 3);
                    ins.op = (s == 0) ? 7'b0110111 : (s == 1) ? 7'b1101111 :
                             (s == 2) ? 7'b0000000 : 7'b1110011;
                end
                ins.flush = ($urandom_range(0, 9) == 0);
            end
            live = !ins.flush && !squash &&
                   (ins.op == OP_R || ins.op == OP_I || ins.op == OP_LW ||
                    ins.op == OP_SW || ins.op == OP_BR);
            e.live = live;
            e.rd = ins.rd;
            if (live) begin
                addr = ins.a + ins.imm;
                idx = int'((addr >> 2) % DMEM_WORDS);
                if (ins.op == OP_R) begin
                    e.we = (ins.rd != 0); e.data = ref_alu(ins.op, ins.f3, ins.f7, ins.a, ins.b);
                end else if (ins.op == OP_I) begin
                    e.we = (ins.rd != 0);
                    e.data = ref_alu(ins.op, ins.f3, ins.f7, ins.a, ins.imm);
                end else if (ins.op == OP_LW) begin
                    e.we = (ins.rd != 0); e.lw = 1'b1; e.data = mem_m[idx];
                end else if (ins.op == OP_SW) begin
                    mem_m[idx] = ins.b;
                    stored_q.push_back(idx);
                end else begin
                    e.br = 1'b1; e.taken = ref_taken(ins.f3, ins.a, ins.b);
                    e.tgt = ins.pc + ins.imm;
                end
            end
            squash = e.br && e.taken;
            rec1 = rec0;
            rec0 = ins.rd;
            drive(ins);
            tick();
            checks++; if (PCSrc !== (e.br && e.taken)) begin failures++;
                $display("FAIL rand_pcsrc j=%0d got=%0b exp=%0b", j, PCSrc, e.br && e.taken); end
            if (e.br) begin
                checks++; if (PC_Branch !== e.tgt) begin failures++;
                    $display("FAIL rand_target j=%0d got=%h exp=%h", j, PC_Branch, e.tgt); end
            end
            checks++; if (MemRead_EX !== e.lw) begin failures++;
                $display("FAIL rand_memread j=%0d got=%0b exp=%0b", j, MemRead_EX, e.lw); end
            if (e.live) begin
                checks++; if (RD_EX !== e.rd) begin failures++;
                    $display("FAIL rand_rd_ex j=%0d got=%0d exp=%0d", j, RD_EX, e.rd); end
            end
            expq.push_back(e);
            if (expq.size() == 3) begin
                w = expq.pop_front();
                checks++; if (RegWrite_WB !== w.we) begin failures++;
                    $display("FAIL rand_we j=%0d got=%0b exp=%0b", j, RegWrite_WB, w.we); end
                if (w.we) begin
                    checks++; if (ALU_DATA_WB !== w.data || RD_WB !== w.rd) begin failures++;
                        $display("FAIL rand_wb j=%0d got=%h rd=%0d exp=%h rd=%0d", j,
                                 ALU_DATA_WB, RD_WB, w.data, w.rd); end
                end
            end
        end
        bubbles(3);
    endtask

    initial begin
        reset = 1'b1;
        drive(nop());
        test_reset();
        test_r_type();
        test_i_type();
        test_branch();
        test_sw_lw();
        test_reset_store();
        test_forwarding();
        test_random(600);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
